// File: rtl/definitions_pkg.sv
// Shared MIPS32 definitions: SPECIAL funct codes plus the multiply/divide unit's
// operation and state encodings.
package definitions_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010_000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010_010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011_000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011_001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011_010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011_011;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE  = 2'd0,
    MDU_CALC  = 2'd1,
    MDU_FIXUP = 2'd2,
    MDU_DONE  = 2'd3
  } mdu_state_t;

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mips_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle over a shared
// 2*XLEN shift register and a single XLEN+1 adder/subtractor.
module mips_mdu
  import definitions_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  mdu_op_t         op_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            div0_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned AW    = XLEN + 1;
  localparam int unsigned PW    = 2 * XLEN;

  mdu_state_t       state_q, state_n;
  mdu_op_t          op_q;
  logic             sign_a_q, sign_b_q, zero_div_q;
  logic [XLEN-1:0]  opnd_q, a_raw_q;
  logic [PW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c, commit_c, op_is_div_c;
  logic             rs_neg_c, rt_neg_c;
  logic [XLEN-1:0]  rs_mag_c, rt_mag_c;
  logic [AW-1:0]    add_a_c, add_b_c, sum_c;
  logic [PW-1:0]    step_c, fix_c;
  logic [XLEN-1:0]  quo_c, rem_c;

  assign accept_c    = (state_q == MDU_IDLE) && start_i && !flush_i;
  assign commit_c    = (state_q == MDU_FIXUP) && !flush_i;
  assign op_is_div_c = mdu_is_div(op_q);

  // Operand conditioning at accept: signed ops work on magnitudes
  assign rs_neg_c = mdu_is_signed(op_i) && rs_i[XLEN-1];
  assign rt_neg_c = mdu_is_signed(op_i) && rt_i[XLEN-1];
  assign rs_mag_c = rs_neg_c ? (XLEN'(0) - rs_i) : rs_i;
  assign rt_mag_c = rt_neg_c ? (XLEN'(0) - rt_i) : rt_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_n;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_n = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        ready_o = 1'b1;
        if (accept_c) state_n = MDU_CALC;
      end
      MDU_CALC: begin
        busy_o = 1'b1;
        if (flush_i)                     state_n = MDU_IDLE;
        else if (cnt_q == CNT_W'(1))     state_n = MDU_FIXUP;
      end
      MDU_FIXUP: begin
        busy_o  = 1'b1;
        state_n = flush_i ? MDU_IDLE : MDU_DONE;
      end
      MDU_DONE: state_n = MDU_IDLE;
      default:  state_n = MDU_IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    add_a_c = op_is_div_c ? acc_q[PW-1:XLEN-1] : {1'b0, acc_q[PW-1:XLEN]};
    add_b_c = op_is_div_c ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    sum_c   = add_a_c + add_b_c + AW'(op_is_div_c);
    step_c  = acc_q;
    if (op_is_div_c) begin
      if (!sum_c[XLEN]) step_c = {sum_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else              step_c = {acc_q[PW-2:0], 1'b0};
    end else begin
      if (acc_q[0]) step_c = {sum_c, acc_q[XLEN-1:1]};
      else          step_c = {1'b0, acc_q[PW-1:1]};
    end
  end

  // Sign correction; a zero divisor overrides with all-ones / raw dividend
  always_comb begin
    quo_c = (sign_a_q ^ sign_b_q) ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_c = sign_a_q ? (XLEN'(0) - acc_q[PW-1:XLEN]) : acc_q[PW-1:XLEN];
    fix_c = acc_q;
    if (op_is_div_c) begin
      if (zero_div_q) begin
        quo_c = '1;
        rem_c = a_raw_q;
      end
      fix_c = {rem_c, quo_c};
    end else if (sign_a_q ^ sign_b_q) begin
      fix_c = PW'(0) - acc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= MDU_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      zero_div_q <= 1'b0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else if (accept_c) begin
      op_q       <= op_i;
      sign_a_q   <= rs_neg_c;
      sign_b_q   <= rt_neg_c;
      zero_div_q <= mdu_is_div(op_i) && (rt_i == '0);
      a_raw_q    <= rs_i;
      cnt_q      <= CNT_W'(XLEN);
      if (mdu_is_div(op_i)) begin
        opnd_q <= rt_mag_c;
        acc_q  <= {XLEN'(0), rs_mag_c};
      end else begin
        opnd_q <= rs_mag_c;
        acc_q  <= {XLEN'(0), rt_mag_c};
      end
    end else if (state_q == MDU_CALC) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= step_c;
    end
  end

  // Architectural HI/LO and status, committed on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
      div0_o <= 1'b0;
    end else begin
      done_o <= commit_c;
      if (commit_c) {hi_o, lo_o} <= fix_c;
      if (accept_c)                      div0_o <= 1'b0;
      else if (commit_c && zero_div_q)   div0_o <= 1'b1;
    end
  end

endmodule
